kd_sort_ctrl: RTL

- Sequencer that owns a NODES-entry array of packed cluster centers laid out as an implicit binary tree (children of node i are 2i+1 and 2i+2).
- Repeatedly sweeps every internal node through one external compare-exchange (CE) unit until a full pass makes no change.
- Centers are loaded as a stream; the settled array is drained as a stream.
- Sits between the center-update logic and the kd-tree search; it is the only driver of the CE node.

---
 rtl/kd_sort_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/kd_sort_ctrl.sv
// Compare-exchange sequencer for an implicit binary tree of packed centers.
// Loads centers as a stream, sweeps internal nodes through an external CE until settled, then drains.
module kd_sort_ctrl #(
    parameter  int DIM        = 3,
    parameter  int DATA_RANGE = 255,
    parameter  int NODES      = 7,
    parameter  int MAX_PASS   = 16,
    localparam int DW         = $clog2(DATA_RANGE),
    localparam int CW         = DIM * DW,
    localparam int IW         = $clog2(NODES),
    localparam int PW         = $clog2(MAX_PASS + 1),
    localparam int AW         = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [CW-1:0] load_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [PW-1:0] pass_cnt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_data,
    output logic          out_last,
    output logic          ce_en,
    output logic          ce_sorting,
    output logic          ce_left_en,
    output logic          ce_right_en,
    output logic [CW-1:0] ce_left,
    output logic [CW-1:0] ce_parent,
    output logic [CW-1:0] ce_right,
    output logic [AW-1:0] ce_axis,
    input  logic [CW-1:0] ce_new_left,
    input  logic [CW-1:0] ce_new_parent,
    input  logic [CW-1:0] ce_new_right
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ISSUE    = 3'd1;
    localparam logic [2:0] ST_WB       = 3'd2;
    localparam logic [2:0] ST_PASS_END = 3'd3;
    localparam logic [2:0] ST_DRAIN    = 3'd4;

    localparam logic [IW+1:0] NODES_W   = (IW+2)'(NODES);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NODES - 1);
    localparam logic [IW-1:0] LAST_NODE = IW'(NODES / 2 - 1);
    localparam logic [PW-1:0] MAX_PASS_W = PW'(MAX_PASS);

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] load_ptr_q, load_ptr_d;
    logic [IW-1:0] node_q, node_d;
    logic [IW-1:0] drain_q, drain_d;
    logic [PW-1:0] pass_q, pass_d;
    logic          err_q, err_d;
    logic          dirty_q, dirty_d;
    logic          done_q, done_d;
    logic [CW-1:0] mem_q [NODES];

    logic [IW+1:0] l_full_s, r_full_s;
    logic          l_en_s, r_en_s;
    logic [IW-1:0] l_idx_s, r_idx_s;
    logic          wb_diff_s;

    // Tree depth of a node (floor(log2(i+1))) folded onto the coordinate axes.
    function automatic logic [AW-1:0] axis_of(input logic [IW-1:0] idx);
        logic [IW:0] n;
        int          d;
        n = {1'b0, idx} + (IW+1)'(1);
        d = 0;
        for (int b = 0; b <= IW; b++) begin
            if (n[b]) d = b;
        end
        return AW'(d % DIM);
    endfunction

    assign l_full_s = {1'b0, node_q, 1'b1};
    assign r_full_s = l_full_s + (IW+2)'(1);
    assign l_en_s   = (l_full_s < NODES_W);
    assign r_en_s   = (r_full_s < NODES_W);
    assign l_idx_s  = l_en_s ? l_full_s[IW-1:0] : '0;
    assign r_idx_s  = r_en_s ? r_full_s[IW-1:0] : '0;

    assign wb_diff_s = (ce_new_parent != mem_q[node_q])
                     | (l_en_s && (ce_new_left  != mem_q[l_idx_s]))
                     | (r_en_s && (ce_new_right != mem_q[r_idx_s]));

    // Next-state and control-register update for the sort sequencer.
    always_comb begin
        state_d    = state_q;
        load_ptr_d = load_ptr_q;
        node_d     = node_q;
        drain_d    = drain_q;
        pass_d     = pass_q;
        err_d      = err_q;
        dirty_d    = dirty_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    load_ptr_d = (load_ptr_q == LAST_IDX) ? '0 : load_ptr_q + IW'(1);
                end else if (start) begin
                    load_ptr_d = '0;
                    node_d     = '0;
                    pass_d     = '0;
                    err_d      = 1'b0;
                    dirty_d    = 1'b0;
                    state_d    = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: state_d = ST_WB;
            ST_WB: begin
                dirty_d = dirty_q | wb_diff_s;
                if (node_q == LAST_NODE) begin
                    state_d = ST_PASS_END;
                end else begin
                    node_d  = node_q + IW'(1);
                    state_d = ST_ISSUE;
                end
            end
            ST_PASS_END: begin
                pass_d = pass_q + PW'(1);
                if (!dirty_q) begin
                    state_d = ST_DRAIN;
                end else if (pass_d == MAX_PASS_W) begin
                    err_d   = 1'b1;
                    state_d = ST_DRAIN;
                end else begin
                    dirty_d = 1'b0;
                    node_d  = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (drain_q == LAST_IDX) begin
                        drain_d = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        drain_d = drain_q + IW'(1);
                    end
                end else begin
                    drain_d = drain_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers; the array itself is deliberately left out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            load_ptr_q <= '0;
            node_q     <= '0;
            drain_q    <= '0;
            pass_q     <= '0;
            err_q      <= 1'b0;
            dirty_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_ptr_q <= load_ptr_d;
            node_q     <= node_d;
            drain_q    <= drain_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            dirty_q    <= dirty_d;
            done_q     <= done_d;
        end
    end

    // Center array writes: stream loads in IDLE, CE results in WB.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && load_valid) begin
            mem_q[load_ptr_q] <= load_data;
        end else if (state_q == ST_WB) begin
            mem_q[node_q] <= ce_new_parent;
            if (l_en_s) mem_q[l_idx_s] <= ce_new_left;
            if (r_en_s) mem_q[r_idx_s] <= ce_new_right;
        end
    end

    assign load_ready  = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign pass_cnt    = pass_q;
    assign out_valid   = (state_q == ST_DRAIN);
    assign out_data    = (state_q == ST_DRAIN) ? mem_q[drain_q] : '0;
    assign out_last    = (state_q == ST_DRAIN) && (drain_q == LAST_IDX);
    assign ce_en       = (state_q == ST_ISSUE);
    assign ce_sorting  = (state_q == ST_ISSUE);
    assign ce_left_en  = (state_q == ST_ISSUE) && l_en_s;
    assign ce_right_en = (state_q == ST_ISSUE) && r_en_s;
    assign ce_left     = ((state_q == ST_ISSUE) && l_en_s) ? mem_q[l_idx_s] : '0;
    assign ce_right    = ((state_q == ST_ISSUE) && r_en_s) ? mem_q[r_idx_s] : '0;
    assign ce_parent   = (state_q == ST_ISSUE) ? mem_q[node_q] : '0;
    assign ce_axis     = axis_of(node_q);

endmodule
